// File: rtl/clock_ctrl_pkg.sv
// Shared mode encoding, BCD constants and small helpers for the clock_ctrl block.
package clock_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } mode_t;

    localparam logic [3:0] BCD_FIVE = 4'd5;
    localparam logic [3:0] BCD_NINE = 4'd9;

    // Exact digit match, so a non-BCD digit can never produce a carry.
    function automatic logic is_bcd_59(input logic [3:0] tens, input logic [3:0] units);
        return (tens == BCD_FIVE) && (units == BCD_NINE);
    endfunction

    function automatic mode_t next_mode(input mode_t cur);
        case (cur)
            RUN:     return SET_HR;
            SET_HR:  return SET_MIN;
            default: return RUN;
        endcase
    endfunction

endpackage

// File: rtl/clock_ctrl_if.sv
// Key, BCD and enable bundle between the run/set controller (master) and the counter datapath (slave).
interface clock_ctrl_if;
    import clock_pkg::*;

    logic              key_mode;
    logic              key_adj;
    logic [3:0]        sec_h;
    logic [3:0]        sec_l;
    logic [3:0]        min_h;
    logic [3:0]        min_l;
    logic              sec_en;
    logic              min_en;
    logic              hr_en;
    logic              sec_clr;
    logic [MODE_W-1:0] mode;
    logic              blink;

    modport master (
        input  key_mode, key_adj, sec_h, sec_l, min_h, min_l,
        output sec_en, min_en, hr_en, sec_clr, mode, blink
    );

    modport slave (
        output key_mode, key_adj, sec_h, sec_l, min_h, min_l,
        input  sec_en, min_en, hr_en, sec_clr, mode, blink
    );

endinterface

// File: rtl/clock_ctrl_key_edge.sv
// Two-flop synchronizer for an asynchronous key level followed by a registered one-cycle rising-edge pulse.
module key_edge (
    input  logic CP,
    input  logic nCR,
    input  logic key_in,
    output logic press
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic press_q, press_d;

    // Flops clear to 0, so a key held through reset release still yields one press.
    always_comb begin
        sync1_d = key_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        press_d = sync2_q & ~prev_q;
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/clock_ctrl.sv
// Digital-clock run/set controller: 1 Hz prescaler, key-driven mode FSM, carry decode and registered enables.
// Optional display blink divider is built only when CLOCK_CTRL_BLINK_EN is defined.
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
`ifdef CLOCK_CTRL_BLINK_EN
    ,
    parameter int BLINK_DIV = TICK_DIV / 2
`endif
) (
    input  logic          CP,
    input  logic          nCR,
    clock_ctrl_if.master  bus
);

    localparam int             PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PCNT_LAST  = PW'(TICK_DIV - 1);

    logic          p_mode;
    logic          p_adj;
    logic          tick;
    logic          sec59;
    logic          min59;

    mode_t         mode_q,    mode_d;
    logic [PW-1:0] pcnt_q,    pcnt_d;
    logic          sec_en_q,  sec_en_d;
    logic          min_en_q,  min_en_d;
    logic          hr_en_q,   hr_en_d;
    logic          sec_clr_q, sec_clr_d;

    key_edge u_key_mode (
        .CP     (CP),
        .nCR    (nCR),
        .key_in (bus.key_mode),
        .press  (p_mode)
    );

    key_edge u_key_adj (
        .CP     (CP),
        .nCR    (nCR),
        .key_in (bus.key_adj),
        .press  (p_adj)
    );

    // Prescaler idles at 0 outside RUN and during the seconds clear, so RUN restarts a full period.
    always_comb begin
        tick  = (mode_q == RUN) && (pcnt_q == PCNT_LAST);
        sec59 = is_bcd_59(bus.sec_h, bus.sec_l);
        min59 = is_bcd_59(bus.min_h, bus.min_l);
        if ((mode_q != RUN) || sec_clr_q || (pcnt_q == PCNT_LAST)) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PW'(1);
        end
    end

    // Mode key has priority: an adjust press in the same cycle as a mode press is dropped.
    always_comb begin
        mode_d    = mode_q;
        sec_en_d  = tick;
        min_en_d  = 1'b0;
        hr_en_d   = 1'b0;
        sec_clr_d = 1'b0;
        if (p_mode) begin
            mode_d = next_mode(mode_q);
        end
        case (mode_q)
            RUN: begin
                min_en_d = tick & sec59;
                hr_en_d  = tick & sec59 & min59;
            end
            SET_HR: begin
                hr_en_d = p_adj & ~p_mode;
            end
            SET_MIN: begin
                min_en_d  = p_adj & ~p_mode;
                sec_clr_d = p_mode;
            end
            default: begin
                mode_d = RUN;
            end
        endcase
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            mode_q    <= RUN;
            pcnt_q    <= '0;
            sec_en_q  <= 1'b0;
            min_en_q  <= 1'b0;
            hr_en_q   <= 1'b0;
            sec_clr_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            pcnt_q    <= pcnt_d;
            sec_en_q  <= sec_en_d;
            min_en_q  <= min_en_d;
            hr_en_q   <= hr_en_d;
            sec_clr_q <= sec_clr_d;
        end
    end

    assign bus.mode    = mode_q;
    assign bus.sec_en  = sec_en_q;
    assign bus.min_en  = min_en_q;
    assign bus.hr_en   = hr_en_q;
    assign bus.sec_clr = sec_clr_q;

`ifdef CLOCK_CTRL_BLINK_EN
    localparam int            BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BCNT_LAST  = BW'(BLINK_DIV - 1);

    logic [BW-1:0] bcnt_q,  bcnt_d;
    logic          blink_q, blink_d;

    // Any mode change or adjust press restarts the blink phase with the field visible.
    always_comb begin
        bcnt_d  = bcnt_q;
        blink_d = blink_q;
        if ((mode_q == RUN) || p_mode || p_adj) begin
            bcnt_d  = '0;
            blink_d = 1'b0;
        end else if (bcnt_q == BCNT_LAST) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
        end else begin
            bcnt_d  = bcnt_q + BW'(1);
        end
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            bcnt_q  <= '0;
            blink_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            blink_q <= blink_d;
        end
    end

    assign bus.blink = blink_q;
`else
    assign bus.blink = 1'b0;
`endif

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: directed vectors and sequences, then random keys/BCD against a reference model.
module tb_clock_ctrl;
    import clock_pkg::*;

    localparam int TICK_DIV = 4;
`ifdef CLOCK_CTRL_BLINK_EN
    localparam int BLINK_DIV = 3;
`endif
    localparam int HIST = 4096;

    logic CP = 1'b0;
    logic nCR;

    clock_ctrl_if bus();

    always #5 CP = ~CP;

    clock_ctrl #(
        .TICK_DIV (TICK_DIV)
`ifdef CLOCK_CTRL_BLINK_EN
        ,
        .BLINK_DIV (BLINK_DIV)
`endif
    ) dut (
        .CP  (CP),
        .nCR (nCR),
        .bus (bus.master)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0] sh, sl, mh, ml;
        logic       e_sec, e_min, e_hr;
    } run_vec_t;

    run_vec_t vecs[7];

    // Reference model: history of sampled key levels, cycle-number bookkeeping for ticks and blink.
    bit         km[HIST];
    bit         ka[HIST];
    int         m_cyc;
    int         m_mode;
    int         m_run_start;
    int         m_blink_start;
    logic [6:0] m_exp;

    function automatic bit km_at(input int n);
        return (n >= 1 && n < HIST) ? km[n] : 1'b0;
    endfunction

    function automatic bit ka_at(input int n);
        return (n >= 1 && n < HIST) ? ka[n] : 1'b0;
    endfunction

    function automatic bit is_59(input logic [3:0] tens, input logic [3:0] units);
        if (tens > 4'd9 || units > 4'd9) return 1'b0;
        return (int'(tens) * 10 + int'(units)) == 59;
    endfunction

    always @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            m_cyc         <= 0;
            m_mode        <= 0;
            m_run_start   <= 0;
            m_blink_start <= 0;
            m_exp         <= '0;
        end else begin : step
            int e, i, nmode, nrun, nblink;
            bit pm, pa, tick, s59, m59, e_min, e_hr, e_clr, e_blink;
            e      = m_cyc + 1;
            i      = e - 1;
            pm     = km_at(i - 2) & ~km_at(i - 3);
            pa     = ka_at(i - 2) & ~ka_at(i - 3);
            tick   = (m_mode == 0) && (i >= m_run_start) &&
                     (((i - m_run_start) % TICK_DIV) == TICK_DIV - 1);
            s59    = is_59(bus.sec_h, bus.sec_l);
            m59    = is_59(bus.min_h, bus.min_l);
            nmode  = pm ? (m_mode + 1) % 3 : m_mode;
            e_min  = (tick && s59) || (m_mode == 2 && pa && !pm);
            e_hr   = (tick && s59 && m59) || (m_mode == 1 && pa && !pm);
            e_clr  = (m_mode == 2) && pm;
            nrun   = e_clr ? e + 1 : m_run_start;
            nblink = (pm || (pa && m_mode != 0)) ? e : m_blink_start;
`ifdef CLOCK_CTRL_BLINK_EN
            e_blink = (nmode != 0) && ((((e - nblink) / BLINK_DIV) % 2) == 1);
`else
            e_blink = 1'b0;
`endif
            if (e < HIST) begin
                km[e] <= bus.key_mode;
                ka[e] <= bus.key_adj;
            end
            m_cyc         <= e;
            m_mode        <= nmode;
            m_run_start   <= nrun;
            m_blink_start <= nblink;
            m_exp         <= {2'(nmode), tick, e_min, e_hr, e_clr, e_blink};
        end
    end

    function automatic logic [6:0] dut_vec();
        return {bus.mode, bus.sec_en, bus.min_en, bus.hr_en, bus.sec_clr, bus.blink};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CP);
    endtask

    task automatic set_bcd(input logic [3:0] sh, input logic [3:0] sl,
                           input logic [3:0] mh, input logic [3:0] ml);
        bus.sec_h = sh;
        bus.sec_l = sl;
        bus.min_h = mh;
        bus.min_l = ml;
    endtask

    task automatic apply_reset();
        nCR          = 1'b0;
        bus.key_mode = 1'b0;
        bus.key_adj  = 1'b0;
        idle(2);
        nCR = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge after the edge where mode must change.
    task automatic press_mode(input logic [1:0] old_mode, input logic [1:0] new_mode);
        bus.key_mode = 1'b1;
        idle(3);
        check_output("mode_hold", 32'(bus.mode), 32'(old_mode));
        idle(1);
        check_output("mode_step", 32'(bus.mode), 32'(new_mode));
        bus.key_mode = 1'b0;
    endtask

    task automatic wait_sec_en(output int n);
        n = 0;
        do begin
            @(negedge CP);
            n++;
        end while (!bus.sec_en && n < 20);
    endtask

    task automatic apply_stimulus();
        if ($urandom_range(0, 9) == 0) bus.key_mode = ~bus.key_mode;
        if ($urandom_range(0, 5) == 0) bus.key_adj  = ~bus.key_adj;
        if ($urandom_range(0, 2) == 0) begin
            bus.sec_h = 4'd5;
            bus.sec_l = 4'd9;
        end else begin
            bus.sec_h = 4'($urandom_range(0, 7));
            bus.sec_l = 4'($urandom_range(0, 15));
        end
        if ($urandom_range(0, 2) == 0) begin
            bus.min_h = 4'd5;
            bus.min_l = 4'd9;
        end else begin
            bus.min_h = 4'($urandom_range(0, 7));
            bus.min_l = 4'($urandom_range(0, 15));
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n, c_sec, c_min, c_hr, exp_blink;

        vecs[0] = '{sh: 4'd5, sl: 4'd9, mh: 4'd5, ml: 4'd9, e_sec: 1'b1, e_min: 1'b1, e_hr: 1'b1};
        vecs[1] = '{sh: 4'd5, sl: 4'd9, mh: 4'd1, ml: 4'd2, e_sec: 1'b1, e_min: 1'b1, e_hr: 1'b0};
        vecs[2] = '{sh: 4'd0, sl: 4'd0, mh: 4'd5, ml: 4'd9, e_sec: 1'b1, e_min: 1'b0, e_hr: 1'b0};
        vecs[3] = '{sh: 4'd5, sl: 4'd15, mh: 4'd5, ml: 4'd9, e_sec: 1'b1, e_min: 1'b0, e_hr: 1'b0};
        vecs[4] = '{sh: 4'd3, sl: 4'd9, mh: 4'd5, ml: 4'd9, e_sec: 1'b1, e_min: 1'b0, e_hr: 1'b0};
        vecs[5] = '{sh: 4'd5, sl: 4'd9, mh: 4'd5, ml: 4'd15, e_sec: 1'b1, e_min: 1'b1, e_hr: 1'b0};
        vecs[6] = '{sh: 4'd5, sl: 4'd9, mh: 4'd6, ml: 4'd9, e_sec: 1'b1, e_min: 1'b1, e_hr: 1'b0};

        nCR          = 1'b0;
        bus.key_mode = 1'b0;
        bus.key_adj  = 1'b0;
        set_bcd(4'd0, 4'd0, 4'd0, 4'd0);

        // Reset state, then free-running prescaler with no carries.
        @(negedge CP);
        check_output("reset_outputs", 32'(dut_vec()), 32'h0);
        apply_reset();
        for (int k = 1; k <= 40; k++) begin
            @(negedge CP);
            check_output("sec_en_period", 32'(bus.sec_en), 32'((k % 4) == 0));
            check_output("no_carry", 32'({bus.min_en, bus.hr_en}), 32'h0);
        end

        // Carry decode table, one vector per tick.
        for (int v = 0; v < 7; v++) begin
            set_bcd(vecs[v].sh, vecs[v].sl, vecs[v].mh, vecs[v].ml);
            wait_sec_en(n);
            check_output("tick_spacing", 32'(n), 32'(TICK_DIV));
            check_output("carry_decode", 32'({bus.sec_en, bus.min_en, bus.hr_en}),
                         32'({vecs[v].e_sec, vecs[v].e_min, vecs[v].e_hr}));
        end

        // Mode stepping and the seconds clear / prescaler restart on return to RUN.
        set_bcd(4'd0, 4'd0, 4'd0, 4'd0);
        idle(1);
        press_mode(2'b00, 2'b01);
        idle(1);
        press_mode(2'b01, 2'b10);
        check_output("no_clr_entering_set_min", 32'(bus.sec_clr), 32'h0);
        idle(1);
        press_mode(2'b10, 2'b00);
        check_output("sec_clr_pulse", 32'(bus.sec_clr), 32'h1);
        n = 0;
        do begin
            @(negedge CP);
            n++;
            if (n == 1) check_output("sec_clr_single", 32'(bus.sec_clr), 32'h0);
        end while (!bus.sec_en && n < 12);
        check_output("first_run_sec_en", 32'(n), 32'(TICK_DIV + 1));

        // SET_MIN adjust: one pulse per press, no carry into hours, no repeat while held.
        idle(1);
        press_mode(2'b00, 2'b01);
        idle(1);
        press_mode(2'b01, 2'b10);
        set_bcd(4'd5, 4'd9, 4'd5, 4'd9);
        idle(1);
        c_sec = 0; c_min = 0; c_hr = 0;
        bus.key_adj = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge CP);
            if (k == 0) bus.key_adj = 1'b0;
            c_sec += int'(bus.sec_en);
            c_min += int'(bus.min_en);
            c_hr  += int'(bus.hr_en);
        end
        check_output("adj_min_pulses", 32'(c_min), 32'd1);
        check_output("adj_no_hr", 32'(c_hr), 32'd0);
        check_output("adj_no_sec", 32'(c_sec), 32'd0);
        c_min = 0; c_hr = 0;
        bus.key_adj = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge CP);
            if (k == 19) bus.key_adj = 1'b0;
            c_min += int'(bus.min_en);
            c_hr  += int'(bus.hr_en);
        end
        check_output("held_adj_min_pulses", 32'(c_min), 32'd1);
        check_output("held_adj_no_hr", 32'(c_hr), 32'd0);

        // Simultaneous mode and adjust press in SET_HR: mode wins.
        press_mode(2'b10, 2'b00);
        idle(1);
        press_mode(2'b00, 2'b01);
        idle(1);
        c_min = 0; c_hr = 0;
        bus.key_mode = 1'b1;
        bus.key_adj  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge CP);
            c_min += int'(bus.min_en);
            c_hr  += int'(bus.hr_en);
        end
        bus.key_mode = 1'b0;
        bus.key_adj  = 1'b0;
        check_output("mode_wins_mode", 32'(bus.mode), 32'h2);
        check_output("mode_wins_no_hr", 32'(c_hr), 32'd0);
        check_output("mode_wins_no_min", 32'(c_min), 32'd0);

        // Asynchronous reset in SET_MIN, then a full prescaler period before the first tick.
        idle(2);
        #2;
        nCR = 1'b0;
        #1;
        check_output("async_reset_outputs", 32'(dut_vec()), 32'h0);
        @(negedge CP);
        nCR = 1'b1;
        wait_sec_en(n);
        check_output("post_reset_sec_en", 32'(n), 32'(TICK_DIV));

        // Blink phase in SET_HR with an adjust press forcing the field visible.
        press_mode(2'b00, 2'b01);
        for (int j = 0; j <= 20; j++) begin
`ifdef CLOCK_CTRL_BLINK_EN
            exp_blink = (j < 15) ? ((j / BLINK_DIV) % 2) : (((j - 15) / BLINK_DIV) % 2);
`else
            exp_blink = 0;
`endif
            check_output("blink", 32'(bus.blink), 32'(exp_blink));
            if (j == 11) bus.key_adj = 1'b1;
            if (j == 14) bus.key_adj = 1'b0;
            @(negedge CP);
        end
        press_mode(2'b01, 2'b10);
        idle(1);
        press_mode(2'b10, 2'b00);
        idle(2);

        // Random keys and BCD against the reference model.
        apply_reset();
        for (int k = 0; k < 3000; k++) begin
            check_output("model", 32'(dut_vec()), 32'(m_exp));
            apply_stimulus();
            @(negedge CP);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
